// File: rtl/frac_clock_gen_if.sv
// rtl/frac_clock_gen_if.sv - configuration write bus for frac_clock_gen
`timescale 1ns/1ps

interface frac_clock_gen_if #(
  parameter int WIDTH  = 32,
  parameter int CHAN_W = 2
);
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [CHAN_W-1:0] i_wr_chan;
  logic              i_wr_sel;
  logic [WIDTH-1:0]  i_wr_data;

  modport master (
    output i_wr_valid, i_wr_chan, i_wr_sel, i_wr_data,
    input  o_wr_ready
  );

  modport slave (
    input  i_wr_valid, i_wr_chan, i_wr_sel, i_wr_data,
    output o_wr_ready
  );
endinterface

// File: rtl/frac_clock_gen.sv
// rtl/frac_clock_gen.sv - multi-channel phase-accumulator clock generator
// Each channel emits wrap ticks, a 50% square wave and a PWM output from one accumulator.
`timescale 1ns/1ps

module frac_clock_gen #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int DEFAULT_HZ = 1,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_en,
  input  logic                i_sync,
  frac_clock_gen_if.slave     wr,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_square,
  output logic [CHANNELS-1:0] o_pwm
);

  localparam logic [63:0]      DEFAULT_INC64 = (64'(DEFAULT_HZ) << WIDTH) / 64'(CLOCK_HZ);
  localparam logic [WIDTH-1:0] DEFAULT_INC   = DEFAULT_INC64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DEFAULT_DUTY  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CHANNELS-1:0] pending;
  logic [31:0]         chan_ext;
  logic                ready;

  assign chan_ext = 32'(wr.i_wr_chan);

  // Out-of-range channels never match below, so they read as ready and are dropped.
  always_comb begin
    ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_ext == 32'(c) && pending[c]) ready = 1'b0;
    end
  end

  assign wr.o_wr_ready = ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] acc, inc, duty, sh_inc, sh_duty;
    logic [WIDTH-1:0] inc_nx, duty_nx;
    logic [WIDTH:0]   sum;
    logic             pend, tick_q, square_q, pwm_q;
    logic             hit, wrap, apply;

    assign hit   = wr.i_wr_valid && ready && (chan_ext == 32'(c));
    assign sum   = {1'b0, acc} + {1'b0, inc};
    assign wrap  = i_en[c] && !i_sync && sum[WIDTH];
    assign apply = pend && (i_sync || !i_en[c] || wrap);

    // The wrapping update adds the old inc; the new values take effect afterwards.
    assign inc_nx  = apply ? sh_inc  : inc;
    assign duty_nx = apply ? sh_duty : duty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        acc      <= '0;
        inc      <= DEFAULT_INC;
        duty     <= DEFAULT_DUTY;
        sh_inc   <= DEFAULT_INC;
        sh_duty  <= DEFAULT_DUTY;
        pend     <= 1'b0;
        tick_q   <= 1'b0;
        square_q <= 1'b0;
        pwm_q    <= 1'b0;
      end else begin
        inc  <= inc_nx;
        duty <= duty_nx;

        // A write landing on an apply edge stays pending for the next one.
        if (hit) begin
          pend <= 1'b1;
          if (wr.i_wr_sel) sh_duty <= wr.i_wr_data;
          else             sh_inc  <= wr.i_wr_data;
        end else if (apply) begin
          pend <= 1'b0;
        end

        if (i_sync) begin
          acc      <= '0;
          tick_q   <= 1'b0;
          square_q <= 1'b0;
          pwm_q    <= (duty_nx != '0);
        end else if (i_en[c]) begin
          acc      <= sum[WIDTH-1:0];
          tick_q   <= sum[WIDTH];
          square_q <= sum[WIDTH-1];
          pwm_q    <= (sum[WIDTH-1:0] < duty_nx);
        end else begin
          tick_q   <= 1'b0;
        end
      end
    end

    assign pending[c]  = pend;
    assign o_tick[c]   = tick_q;
    assign o_square[c] = square_q;
    assign o_pwm[c]    = pwm_q;
  end

endmodule

// File: tb/tb_frac_clock_gen.sv
// tb/tb_frac_clock_gen.sv - directed scoreboard bench for frac_clock_gen
`timescale 1ns/1ps

module tb_frac_clock_gen;
  localparam int W       = 8;
  localparam int CH      = 2;
  localparam int MOD     = 1 << W;
  localparam int HALF    = MOD / 2;
  localparam int DEF_INC = (125 * MOD) / 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic          sync;
  logic [CH-1:0] tick, square, pwm;

  frac_clock_gen_if #(.WIDTH(W), .CHAN_W(1)) wr_if ();

  frac_clock_gen #(
    .WIDTH(W), .CHANNELS(CH), .CLOCK_HZ(1000), .DEFAULT_HZ(125)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync), .wr(wr_if),
    .o_tick(tick), .o_square(square), .o_pwm(pwm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    assert (sb.size() > 0)
    else $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic chan, input logic sel, input logic [W-1:0] data);
    int t;
    t = 0;
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_chan  = chan;
    wr_if.i_wr_sel   = sel;
    wr_if.i_wr_data  = data;
    while (!wr_if.o_wr_ready && t < 64) begin
      cyc();
      t++;
    end
    push("wr_ready_wait", 1);
    check(wr_if.o_wr_ready);
    cyc();
    wr_if.i_wr_valid = 1'b0;
  endtask

  task automatic run_chk(input int ch, input int n, input int inc, input int duty,
                         input int acc0, output int acc_end, output int ticks, output int pwm_hi);
    int a, s;
    a = acc0;
    ticks = 0;
    pwm_hi = 0;
    for (int k = 1; k <= n; k++) begin
      s = a + inc;
      a = s % MOD;
      push($sformatf("tick%0d_k%0d", ch, k), (s >= MOD));
      push($sformatf("square%0d_k%0d", ch, k), (a >= HALF));
      push($sformatf("pwm%0d_k%0d", ch, k), (a < duty));
      cyc();
      ticks  += int'(tick[ch]);
      pwm_hi += int'(pwm[ch]);
      check(tick[ch]);
      check(square[ch]);
      check(pwm[ch]);
    end
    acc_end = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, tk, ph;
    logic [1:0] exp_tick [4];
    logic [1:0] exp_sq   [4];
    logic [1:0] exp_pwm  [4];

    rst_n = 1'b0; en = '0; sync = 1'b0;
    wr_if.i_wr_valid = 1'b0; wr_if.i_wr_chan = 1'b0; wr_if.i_wr_sel = 1'b0; wr_if.i_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_tick", 0);   check(tick);
    push("rst_square", 0); check(square);
    push("rst_pwm", 0);    check(pwm);
    push("rst_ready", 1);  check(wr_if.o_wr_ready);
    rst_n = 1'b1;
    cyc();

    // Default increment on channel 1
    en = 2'b10;
    run_chk(1, 16, DEF_INC, HALF, 0, a1, tk, ph);
    push("def_ticks", 2); check(tk);
    en = 2'b00;

    // inc 64: tick every 4 cycles, square 2 high / 2 low
    write_cfg(1'b0, 1'b0, 8'd64);
    push("pend_ready", 0); check(wr_if.o_wr_ready);
    cyc();
    push("apply_ready", 1); check(wr_if.o_wr_ready);
    en = 2'b01;
    run_chk(0, 12, 64, HALF, 0, a0, tk, ph);
    push("inc64_ticks", 3); check(tk);

    // inc 3 over 256 cycles
    en = 2'b00;
    write_cfg(1'b0, 1'b0, 8'd3);
    cyc();
    en = 2'b01;
    run_chk(0, 256, 3, HALF, a0, a0, tk, ph);
    push("inc3_ticks", 3); check(tk);

    // duty 64, inc 16
    en = 2'b00;
    write_cfg(1'b0, 1'b0, 8'd16); cyc();
    write_cfg(1'b0, 1'b1, 8'd64); cyc();
    en = 2'b01;
    run_chk(0, 32, 16, 64, a0, a0, tk, ph);
    push("pwm_high_count", 8); check(ph);

    // Mid-period inc change and stalled second write
    en = 2'b00;
    write_cfg(1'b0, 1'b0, 8'd64);  cyc();
    write_cfg(1'b0, 1'b1, 8'd128); cyc();
    en = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      push($sformatf("midchg_tick_k%0d", k), (k == 4 || k == 8 || k == 10 || k == 12));
      cyc();
      check(tick[0]);
      case (k)
        6: begin
          wr_if.i_wr_valid = 1'b1; wr_if.i_wr_chan = 1'b0;
          wr_if.i_wr_sel = 1'b0;   wr_if.i_wr_data = 8'd128;
          push("midchg_ready_free", 1); check(wr_if.o_wr_ready);
        end
        7: begin
          push("midchg_stall", 0); check(wr_if.o_wr_ready);
          wr_if.i_wr_sel = 1'b1; wr_if.i_wr_data = 8'd128;
        end
        8: begin push("midchg_ready_after_tick", 1); check(wr_if.o_wr_ready); end
        9: begin
          push("midchg_second_pending", 0); check(wr_if.o_wr_ready);
          wr_if.i_wr_valid = 1'b0;
        end
        10: begin push("midchg_second_applied", 1); check(wr_if.o_wr_ready); end
        default: ;
      endcase
    end

    // Sync coinciding with a ch0 carry
    en = 2'b00;
    write_cfg(1'b1, 1'b0, 8'd64); cyc();
    en = 2'b11;
    push("presync_tick", 2'b00); push("presync_square", 2'b01);
    cyc();
    check(tick); check(square);
    sync = 1'b1;
    push("sync_tick", 2'b00); push("sync_square", 2'b00); push("sync_pwm", 2'b11);
    cyc();
    check(tick); check(square); check(pwm);
    sync = 1'b0;
    exp_tick = '{2'b00, 2'b01, 2'b00, 2'b11};
    exp_sq   = '{2'b01, 2'b10, 2'b11, 2'b00};
    exp_pwm  = '{2'b10, 2'b01, 2'b00, 2'b11};
    for (int k = 0; k < 4; k++) begin
      push($sformatf("postsync_tick_k%0d", k + 1), exp_tick[k]);
      push($sformatf("postsync_square_k%0d", k + 1), exp_sq[k]);
      push($sformatf("postsync_pwm_k%0d", k + 1), exp_pwm[k]);
      cyc();
      check(tick); check(square); check(pwm);
    end

    // Reset with a write pending
    en = 2'b01;
    write_cfg(1'b0, 1'b0, 8'd96);
    push("prerst_pending", 0); check(wr_if.o_wr_ready);
    #2;
    rst_n = 1'b0;
    #1;
    push("midrst_tick", 0);   check(tick);
    push("midrst_square", 0); check(square);
    push("midrst_pwm", 0);    check(pwm);
    push("midrst_ready", 1);  check(wr_if.o_wr_ready);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 2'b01;
    run_chk(0, 16, DEF_INC, HALF, 0, a0, tk, ph);
    push("postrst_ticks", 2); check(tk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frac_clock_gen.md
FRAC_CLOCK_GEN -- requirements
Module: frac_clock_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, phase accumulator width in bits (>= 4).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent accumulator channels (>= 1).
REQ-003 SHALL have parameter CLOCK_HZ, default 50_000_000, input clock frequency.
REQ-004 SHALL have parameter DEFAULT_HZ, default 1, per-channel output frequency after reset.
REQ-005 SHALL have port i_clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_en, input, CHANNELS, per-channel run enable.
REQ-008 SHALL have port i_sync, input, 1, synchronous phase reset of all channels.
REQ-009 SHALL have port i_wr_valid, input, 1, configuration write request.
REQ-010 SHALL have port o_wr_ready, output, 1, configuration write can be accepted.
REQ-011 SHALL have port i_wr_chan, input, max(1,$clog2(CHANNELS)), target channel.
REQ-012 SHALL have port i_wr_sel, input, 1, 0 = increment register, 1 = duty register.
REQ-013 SHALL have port i_wr_data, input, WIDTH, value written.
REQ-014 SHALL have port o_tick, output, CHANNELS, one-cycle pulse per accumulator wrap.
REQ-015 SHALL have port o_square, output, CHANNELS, accumulator MSB (50% square wave).
REQ-016 SHALL have port o_pwm, output, CHANNELS, high while accumulator < duty.

Function
REQ-017 SHALL hold per channel: acc, active inc, active duty, shadow inc, shadow duty, pending flag.
REQ-018 SHALL compute DEFAULT_INC = floor(DEFAULT_HZ * 2^WIDTH / CLOCK_HZ) at elaboration in 64-bit arithmetic, truncated to WIDTH.
REQ-019 SHALL, per enabled channel with i_sync low, update acc <= (acc + inc) mod 2^WIDTH each cycle.
REQ-020 SHALL assert o_tick[c] for exactly the cycle following an update whose sum carried out of bit WIDTH-1.
REQ-021 SHALL register o_square[c] = new acc[WIDTH-1] and o_pwm[c] = (new acc < active duty), both updated on the same edge as acc.
REQ-022 SHALL, for a disabled channel, hold acc, o_square and o_pwm, and drive o_tick[c] low.
REQ-023 SHALL treat inc = 0 as stopped: acc holds, no tick.
REQ-024 SHALL drive o_wr_ready = !pending[i_wr_chan] combinationally; i_wr_chan >= CHANNELS gives o_wr_ready = 1 and the write is discarded.
REQ-025 SHALL, on i_wr_valid && o_wr_ready, write i_wr_data to the selected shadow register and set pending for that channel.
REQ-026 SHALL copy both shadows to active registers and clear pending on the edge where the channel wraps (tick generated), is disabled, or i_sync is high; the wrapping update itself uses the old inc.
REQ-027 SHALL, when a write is accepted in the same cycle as an apply event for that channel, leave the new value pending for the next apply event.
REQ-028 SHALL, on i_sync high, set every acc to 0 regardless of i_en, drive all o_tick low, o_square low, o_pwm = (active duty after apply != 0).
REQ-029 SHALL give i_sync priority over enable and wrap; a carry in the sync cycle produces no tick.

Reset
REQ-030 SHALL, on i_rst_n low, asynchronously set acc = 0, active and shadow inc = DEFAULT_INC, active and shadow duty = 2^(WIDTH-1), pending = 0, o_tick = o_square = o_pwm = 0.
REQ-031 SHALL resume operation on the first rising edge after i_rst_n deasserts; reset mid-write discards the write.

Verification (WIDTH=8, CHANNELS=2)
REQ-032 SHALL cover: inc[0]=64, i_en=01 from acc 0 -> o_tick[0] high 1 cycle every 4 cycles, first after 4th edge; o_square[0] 2 high / 2 low.
REQ-033 SHALL cover: inc[0]=3, run 256 enabled cycles -> exactly 3 o_tick[0] pulses, acc returns to 0.
REQ-034 SHALL cover: write inc=128 to ch0 mid-period with inc 64 -> o_wr_ready low for ch0 until next tick; spacing 4 then 2 cycles; second write while pending stalls.
REQ-035 SHALL cover: duty=64, inc=16 -> o_pwm[0] high 4 of every 16 cycles.
REQ-036 SHALL cover: i_sync pulse coinciding with carry -> no tick, both acc = 0 next cycle, channels realigned.
REQ-037 SHALL cover: i_rst_n low mid-run with pending write -> all outputs 0, inc back to DEFAULT_INC, o_wr_ready = 1.
